multicycle_ctrl: RTL

- Main control FSM for the multicycle RV32I core.
- Sequences the shared PC/ALU/memory datapath through fetch, decode, execute, memory and writeback steps, one state per cycle.
- Drives the PC write enable, IR load, ALU operand and operation selects, result mux, memory address/write, and register-file write.
- Waits on a memory-ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_ctrl_if.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundles the datapath-facing signals of the multicycle
// RV32I control FSM.
//   master modport : the controller (takes decode/status inputs, drives controls)
//   slave modport  : the datapath side (drives decode/status, takes controls)
// Signals:
//   opcode[6:0], funct3_0, zero, mem_ready   - status from the datapath
//   pc_write, ir_write, adr_src, mem_write,
//   reg_write, alu_src_a[1:0], alu_src_b[1:0],
//   alu_op[1:0], result_src[1:0]              - datapath controls
//   instr_done, illegal, state[STATE_W-1:0]   - status/debug from the controller
interface multicycle_ctrl_if #(
    parameter int unsigned STATE_W = 4
);
    logic [6:0]         opcode;
    logic               funct3_0;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               ir_write;
    logic               adr_src;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         result_src;
    logic               instr_done;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct3_0, zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src,
               instr_done, illegal, state
    );

    modport slave (
        output opcode, funct3_0, zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src,
               instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core. Steps the
// shared PC/ALU/memory datapath through fetch, decode, execute, memory and
// writeback, one state per cycle, stalling on mem_ready and trapping
// unsupported opcodes in a sticky ILLEGAL state.
// Ports:
//   clk   - core clock, rising-edge
//   reset - synchronous active-high reset
//   ctl   - multicycle_ctrl_if.master (status in, datapath controls out,
//           sticky illegal flag and debug state out)
// STATE_W must be >= 4 so that all twelve state encodings are visible.
module multicycle_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master ctl
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_JAL       = 4'd9,
        S_BRANCH    = 4'd10,
        S_ILLEGAL   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;

    logic       pc_we, ir_we, mem_we, reg_we, done;
    logic       adr_sel;
    logic [1:0] src_a, src_b, op_sel, res_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        mem_we  = 1'b0;
        reg_we  = 1'b0;
        done    = 1'b0;
        adr_sel = 1'b0;
        src_a   = 2'b00;
        src_b   = 2'b00;
        op_sel  = 2'b00;
        res_sel = 2'b00;

        case (state_q)
            S_FETCH: begin
                src_b   = 2'b10;
                res_sel = 2'b10;
                ir_we   = ctl.mem_ready;
                pc_we   = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (ctl.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = (ctl.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                adr_sel = 1'b1;
                if (ctl.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                res_sel = 2'b01;
                reg_we  = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_sel = 1'b1;
                mem_we  = 1'b1;
                done    = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                src_a   = 2'b10;
                op_sel  = 2'b10;
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                op_sel  = 2'b10;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                pc_we   = 1'b1;
                state_d = S_ALU_WB;
            end
            S_BRANCH: begin
                src_a   = 2'b10;
                op_sel  = 2'b01;
                // bne inverts the sense of the zero flag
                pc_we   = ctl.zero ^ ctl.funct3_0;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // ILLEGAL and any unused encoding: park with everything off
                state_d = S_ILLEGAL;
            end
        endcase

        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    // Enables are squashed while reset is high so an abandoned instruction
    // cannot write anything in the reset cycle.
    assign ctl.pc_write   = pc_we  & ~reset;
    assign ctl.ir_write   = ir_we  & ~reset;
    assign ctl.mem_write  = mem_we & ~reset;
    assign ctl.reg_write  = reg_we & ~reset;
    assign ctl.instr_done = done   & ~reset;
    assign ctl.adr_src    = adr_sel;
    assign ctl.alu_src_a  = src_a;
    assign ctl.alu_src_b  = src_b;
    assign ctl.alu_op     = op_sel;
    assign ctl.result_src = res_sel;
    assign ctl.illegal    = illegal_q;
    assign ctl.state      = STATE_W'(state_q);

endmodule
